// File: rtl/inst_fetch.sv
// Instruction fetch unit: single-outstanding memory request, holds one
// instruction for decode, and redirects on branch/jump consume or flush.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    input  logic        pc_sel_i,
    input  logic [31:0] pc_target_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] fetch_pc_r;
    logic [31:0] fetch_pc_next_s;
    logic [31:0] inst_r;
    logic [31:0] pc_r;
    logic [31:0] pc_plus4_r;
    logic        req_r;
    logic        valid_r;
    logic        load_inst_s;
    logic        consume_s;

    assign consume_s = (state_r == ST_HOLD) && inst_ready_i;

    // Next-state selection; flush overrides every ordinary transition.
    always_comb begin
        next_state_s = state_r;
        load_inst_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                next_state_s = ST_REQ;
            end
            ST_REQ: begin
                if (imem_gnt_i) begin
                    next_state_s = flush_i ? ST_DRAIN : ST_WAIT;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    if (flush_i) begin
                        next_state_s = ST_REQ;
                    end else begin
                        next_state_s = ST_HOLD;
                        load_inst_s  = 1'b1;
                    end
                end else if (flush_i) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (flush_i || inst_ready_i) begin
                    next_state_s = ST_REQ;
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                // A response still owed must be swallowed before re-requesting.
                if (imem_rvalid_i) begin
                    next_state_s = ST_REQ;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Next fetch address: flush first, then the consumed instruction's successor.
    always_comb begin
        if (flush_i) begin
            fetch_pc_next_s = align_pc(flush_pc_i);
        end else if (consume_s) begin
            fetch_pc_next_s = pc_sel_i ? align_pc(pc_target_i) : pc_plus4_r;
        end else begin
            fetch_pc_next_s = fetch_pc_r;
        end
    end

    // State, fetch address and held instruction registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC_ALIGNED;
            inst_r     <= NOP_INST;
            pc_r       <= RESET_PC_ALIGNED;
            pc_plus4_r <= RESET_PC_ALIGNED + 32'd4;
            req_r      <= 1'b0;
            valid_r    <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            fetch_pc_r <= fetch_pc_next_s;
            req_r      <= (next_state_s == ST_REQ);
            valid_r    <= (next_state_s == ST_HOLD);
            if (load_inst_s) begin
                inst_r     <= imem_rdata_i;
                pc_r       <= fetch_pc_r;
                pc_plus4_r <= fetch_pc_r + 32'd4;
            end
        end
    end

    assign imem_req_o   = req_r;
    assign imem_addr_o  = fetch_pc_r;
    assign inst_o       = inst_r;
    assign inst_valid_o = valid_r;
    assign pc_o         = pc_r;
    assign pc_plus4_o   = pc_plus4_r;

endmodule
